// File: rtl/win_banner.sv
// win_banner: draws a column-by-column revealed, then blinking, "WIN" banner over the winner's side
module win_banner #(
    parameter int         SCALE_LOG2    = 2,
    parameter int         P1_X          = 160,
    parameter int         P2_X          = 480,
    parameter int         Y_POS         = 226,
    parameter logic [2:0] P1_CODE       = 3'b100,
    parameter logic [2:0] P2_CODE       = 3'b001,
    parameter int         REVEAL_FRAMES = 4,
    parameter int         BLINK_FRAMES  = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [2:0]  winner,
    output logic        pixel_on,
    output logic        active,
    output logic        reveal_done
);
    typedef enum logic [1:0] {IDLE, REVEAL, SHOW} state_t;

    // column masks of the glyph, bit r = row r; index 15 is a blank guard column
    localparam logic [15:0][7:0] GLYPH = {
        8'h00, 8'h7f, 8'h30, 8'h08, 8'h06, 8'h7f, 8'h00, 8'h7f,
        8'h00, 8'h3f, 8'h00, 8'h40, 8'h3e, 8'h40, 8'h40, 8'h3f
    };
    localparam logic [12:0] W_SPAN = 13'(15 << SCALE_LOG2);
    localparam logic [12:0] H_SPAN = 13'(7 << SCALE_LOG2);
    localparam logic [12:0] Y0     = 13'(Y_POS);

    state_t      state;
    logic [2:0]  win_q;
    logic [12:0] x0;
    logic [3:0]  cols;
    logic [7:0]  cnt;
    logic        blink;
    logic        s1_in;
    logic [3:0]  s1_col;
    logic [2:0]  s1_row;

    logic [12:0] xe, ye, dx, dy;
    logic [7:0]  cnt_inc;
    logic        valid, in_box;

    assign xe      = {1'b0, x};
    assign ye      = {1'b0, y};
    assign dx      = xe - x0;
    assign dy      = ye - Y0;
    assign cnt_inc = cnt + 8'd1;
    assign valid   = (winner == P1_CODE) || (winner == P2_CODE);
    assign in_box  = (xe >= x0) && (xe < x0 + W_SPAN) && (ye >= Y0) && (ye < Y0 + H_SPAN);

    // animation state machine, advanced only on frame ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win_q       <= '0;
            x0          <= '0;
            cols        <= '0;
            cnt         <= '0;
            blink       <= 1'b0;
            active      <= 1'b0;
            reveal_done <= 1'b0;
        end else if (frame_tick) begin
            if (!valid) begin
                state       <= IDLE;
                win_q       <= '0;
                cols        <= '0;
                cnt         <= '0;
                blink       <= 1'b0;
                active      <= 1'b0;
                reveal_done <= 1'b0;
            end else if (state == IDLE || winner != win_q) begin
                state       <= REVEAL;
                win_q       <= winner;
                x0          <= (winner == P1_CODE) ? 13'(P1_X) : 13'(P2_X);
                cols        <= '0;
                cnt         <= '0;
                blink       <= 1'b0;
                active      <= 1'b1;
                reveal_done <= 1'b0;
            end else if (state == REVEAL) begin
                if (cnt_inc == 8'(REVEAL_FRAMES)) begin
                    cnt  <= '0;
                    cols <= cols + 4'd1;
                    if (cols == 4'd14) begin
                        state       <= SHOW;
                        blink       <= 1'b1;
                        reveal_done <= 1'b1;
                    end
                end else begin
                    cnt <= cnt_inc;
                end
            end else if (BLINK_FRAMES > 0) begin
                if (cnt_inc == 8'(BLINK_FRAMES)) begin
                    cnt   <= '0;
                    blink <= ~blink;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    // stage 1: box test and cell coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in  <= 1'b0;
            s1_col <= '0;
            s1_row <= '0;
        end else begin
            s1_in  <= in_box;
            s1_col <= 4'(dx >> SCALE_LOG2);
            s1_row <= 3'(dy >> SCALE_LOG2);
        end
    end

    // stage 2: glyph lookup gated by reveal progress and blink phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pixel_on <= 1'b0;
        else pixel_on <= s1_in && GLYPH[s1_col][s1_row] && (s1_col < cols) &&
                         (state == REVEAL || blink);
    end
endmodule

// File: tb/tb_win_banner.sv
// tb_win_banner: scoreboard bench for the WIN banner renderer
module tb_win_banner;
    localparam logic [2:0] P1 = 3'b100;
    localparam logic [2:0] P2 = 3'b001;
    localparam int RF = 1;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [11:0] x = '0;
    logic [11:0] y = '0;
    logic [2:0]  winner = '0;
    logic        pixel_on, active, reveal_done;

    win_banner #(.REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .x(x), .y(y),
        .winner(winner), .pixel_on(pixel_on), .active(active), .reveal_done(reveal_done)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; logic v;} exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;

    int   ms, mcols, mcnt, mx0;
    logic mblink;
    logic [2:0] mwin;

    string g[7] = '{"100000101010001", "100100101011001", "100100101011001",
                    "100100101010101", "100100101010011", "100100101010011",
                    "011010001010001"};

    task automatic check(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        ms = 0; mcols = 0; mcnt = 0; mx0 = 0; mblink = 1'b0; mwin = '0;
    endtask

    task automatic m_tick(input logic [2:0] w);
        if (w != P1 && w != P2) begin
            ms = 0; mcols = 0; mcnt = 0; mblink = 1'b0; mwin = '0;
        end else if (ms == 0 || w != mwin) begin
            ms = 1; mwin = w; mx0 = (w == P1) ? 160 : 480; mcols = 0; mcnt = 0; mblink = 1'b0;
        end else if (ms == 1) begin
            mcnt++;
            if (mcnt == RF) begin
                mcnt = 0;
                mcols++;
                if (mcols == 15) begin ms = 2; mblink = 1'b1; end
            end
        end else if (BF > 0) begin
            mcnt++;
            if (mcnt == BF) begin mcnt = 0; mblink = ~mblink; end
        end
    endtask

    function automatic logic lit(input int xx, input int yy);
        int c, r;
        if (ms == 0 || xx < mx0 || xx >= mx0 + 60 || yy < 226 || yy >= 226 + 28) return 1'b0;
        c = (xx - mx0) / 4;
        r = (yy - 226) / 4;
        return (g[r][c] == "1") && (c < mcols) && (ms == 1 || mblink);
    endfunction

    task automatic cyc(input logic tk, input int xx, input int yy, input logic [2:0] w);
        exp_t e;
        @(negedge clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            check($sformatf("pix(%0d,%0d)", e.x, e.y), pixel_on, e.v);
        end
        check("active", active, ms != 0);
        check("reveal_done", reveal_done, ms == 2);
        frame_tick = tk; x = 12'(xx); y = 12'(yy); winner = w;
        if (tk) m_tick(w);
        q.push_back('{xx, yy, lit(xx, yy)});
    endtask

    task automatic probe(input int xx, input int yy, input logic [2:0] w);
        cyc(1'b0, xx, yy, w);
    endtask

    task automatic tick(input logic [2:0] w);
        cyc(1'b1, 0, 0, w);
    endtask

    initial begin
        m_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            frame_tick = i[0]; winner = P1; x = 12'd160; y = 12'd226;
            check("rst pixel_on", pixel_on, 1'b0);
            check("rst active", active, 1'b0);
            check("rst reveal_done", reveal_done, 1'b0);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        rst_n = 1'b1;

        tick(P1);
        probe(160, 226, P1);
        for (int t = 1; t <= 15; t++) begin
            tick(P1);
            probe(160, 226, P1);
            probe(216, 226, P1);
        end

        for (int xx = 160; xx < 220; xx++) probe(xx, 250, P1);

        for (int t = 0; t < 4; t++) begin
            tick(P1);
            probe(160, 226, P1);
            probe(160, 226, P1);
        end

        probe(159, 226, P1);
        probe(220, 226, P1);
        probe(160, 225, P1);
        probe(160, 254, P1);
        probe(160, 226, P2);
        probe(480, 226, P2);
        probe(160, 226, P2);

        tick(P2);
        probe(160, 226, P2);
        probe(176, 250, P2);
        probe(480, 226, P2);
        tick(P2);
        probe(480, 226, P2);
        probe(479, 226, P2);
        probe(540, 226, P2);

        tick(3'b000);
        probe(480, 226, 3'b000);
        probe(480, 226, 3'b000);

        tick(P1);
        for (int t = 0; t < 3; t++) tick(P1);
        probe(160, 226, P1);
        probe(160, 226, P1);
        probe(0, 0, P1);
        probe(0, 0, P1);
        #2 rst_n = 1'b0;
        #1;
        check("async active", active, 1'b0);
        check("async pixel_on", pixel_on, 1'b0);
        q.delete();
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            frame_tick = 1'b1; winner = P1; x = 12'd160; y = 12'd226;
            check("rst2 pixel_on", pixel_on, 1'b0);
            check("rst2 reveal_done", reveal_done, 1'b0);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        rst_n = 1'b1;
        probe(160, 226, P1);
        probe(160, 226, P1);
        tick(P1);
        probe(160, 226, P1);
        probe(160, 226, P1);
        tick(P1);
        probe(160, 226, P1);
        probe(164, 226, P1);
        probe(0, 0, P1);
        probe(0, 0, P1);
        probe(0, 0, P1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
